// File: rtl/frame_seq_pkg.sv
// Shared constants and types for the serial-output frame sequencer.
package frame_seq_pkg;

  localparam int unsigned DEF_NUM_SLOTS = 16;
  localparam int unsigned DEF_WORD_BITS = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so single-value counters still get a bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/frame_seq_next_slot.sv
// Priority search: lowest enabled slot index strictly above the current slot.
module frame_seq_next_slot
  import frame_seq_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
  localparam int unsigned SEL_W     = clog2_min1(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] mask,
  input  logic [SEL_W-1:0]     slot,
  output logic [SEL_W-1:0]     next_slot_c,
  output logic                 none_left_c
);

  always_comb begin
    next_slot_c = '0;
    none_left_c = 1'b1;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (none_left_c && mask[i] && (i > 32'(slot))) begin
        next_slot_c = SEL_W'(i);
        none_left_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Transmit sequencer: walks the output mux through masked slots per ovf trigger,
// with a one-deep pending trigger and saturating overrun accounting.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter  int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
  parameter  int unsigned WORD_BITS = DEF_WORD_BITS,
  parameter  int unsigned CNT_W     = 8,
  localparam int unsigned SEL_W     = clog2_min1(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ovf,
  input  logic [NUM_SLOTS-1:0] slot_en,
  output logic [SEL_W-1:0]     sel,
  output logic                 sl,
  output logic                 clr,
  output logic                 busy,
  output logic                 missed,
  output logic [CNT_W-1:0]     missed_cnt
);

  localparam int unsigned      BIT_W    = clog2_min1(WORD_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_BITS - 1);

  state_t                state;
  logic [BIT_W-1:0]      bit_cnt;
  logic [NUM_SLOTS-1:0]  mask;
  logic                  pending;
  logic [SEL_W-1:0]      next_slot_c;
  logic                  none_left_c;
  logic                  drop_c;
  logic                  start_c;

  frame_seq_next_slot #(.NUM_SLOTS(NUM_SLOTS)) u_next_slot (
    .mask        (mask),
    .slot        (sel),
    .next_slot_c (next_slot_c),
    .none_left_c (none_left_c)
  );

  // A trigger is lost only when one is already queued; pending is never set in IDLE.
  assign drop_c  = ovf & pending;
  assign start_c = ((state == ST_IDLE) && ovf) ||
                   ((state == ST_CLEAR) && (pending || ovf));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel        <= '0;
      bit_cnt    <= '0;
      mask       <= '0;
      pending    <= 1'b0;
      sl         <= 1'b0;
      clr        <= 1'b0;
      busy       <= 1'b0;
      missed     <= 1'b0;
      missed_cnt <= '0;
    end else begin
      sl     <= 1'b0;
      clr    <= 1'b0;
      missed <= drop_c;
      if (drop_c && (missed_cnt != '1)) missed_cnt <= missed_cnt + CNT_W'(1);

      if (start_c) begin
        state   <= ST_SEND;
        mask    <= slot_en | NUM_SLOTS'(1);
        sel     <= '0;
        bit_cnt <= '0;
        sl      <= 1'b1;
        busy    <= 1'b1;
        pending <= 1'b0;
      end else begin
        case (state)
          ST_SEND: begin
            if (ovf) pending <= 1'b1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (none_left_c) begin
                state <= ST_CLEAR;
                clr   <= 1'b1;
              end else begin
                sel <= next_slot_c;
                sl  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
          ST_CLEAR: begin
            state <= ST_IDLE;
            sel   <= '0;
            busy  <= 1'b0;
          end
          ST_IDLE: ;
          default: begin
            state <= ST_IDLE;
            sel   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
